// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_arbiter
// Description : Shares one fixed-latency, single-ported unified memory between
//               the fetch stage and the load/store path. Data wins a tie
//               unless it also won the previous tie-eligible grant. New fetch
//               grants are blocked while halt is high.
// Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  halt,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_valid,
    output logic                  if_stall,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_valid,
    output logic                  d_stall,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int            c_BE_W  = DATA_W / 8;
    localparam int            c_CNT_W = 3;
    localparam logic [c_CNT_W-1:0] c_LAT = c_CNT_W'(MEM_LAT);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic                r_last_data;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [c_BE_W-1:0]   r_mem_be;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic w_busy;
    logic w_done;
    logic w_arb;
    logic w_fetch_cand;
    logic w_data_cand;
    logic w_grant_data;
    logic w_grant_fetch;

    // Completion is the cycle the latency counter has run down to zero; the
    // next grant may be taken in that same cycle for back-to-back accesses.
    assign w_busy        = (r_state == c_ST_FETCH) || (r_state == c_ST_DATA);
    assign w_done        = w_busy && (r_cnt == '0);
    assign w_arb         = (r_state == c_ST_IDLE) || w_done;
    assign w_fetch_cand  = if_req & ~halt;
    assign w_data_cand   = d_req;
    assign w_grant_data  = w_arb & w_data_cand & (~w_fetch_cand | ~r_last_data);
    assign w_grant_fetch = w_arb & w_fetch_cand & ~w_grant_data;

    // Completion pulses and read data steering.
    assign if_valid  = w_done && (r_state == c_ST_FETCH);
    assign d_valid   = w_done && (r_state == c_ST_DATA);
    assign if_rdata  = if_valid ? mem_rdata : '0;
    assign d_rdata   = (d_valid && !r_mem_we) ? mem_rdata : '0;
    assign if_stall  = if_req & ~if_valid;
    assign d_stall   = d_req & ~d_valid;

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // Next-state and latency counter selection.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_busy && (r_cnt != '0)) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
        if (w_arb) begin
            if (w_grant_data) begin
                w_state_nxt = c_ST_DATA;
                w_cnt_nxt   = c_LAT;
            end else if (w_grant_fetch) begin
                w_state_nxt = c_ST_FETCH;
                w_cnt_nxt   = c_LAT;
            end else begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        end
    end

    // State, counter and fairness history registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_last_data <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_grant_data) begin
                r_last_data <= 1'b1;
            end else if (w_grant_fetch) begin
                r_last_data <= 1'b0;
            end
        end
    end

    // Memory command registers: captured on a grant, held between strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_en <= w_grant_data | w_grant_fetch;
            if (w_grant_data) begin
                r_mem_we    <= d_we;
                r_mem_be    <= d_be;
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_wdata;
            end else if (w_grant_fetch) begin
                r_mem_we    <= 1'b0;
                r_mem_be    <= '1;
                r_mem_addr  <= if_addr;
                r_mem_wdata <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_unified_mem_arbiter
// Description : Directed stimulus for unified_mem_arbiter with a transaction
//               level reference model checked every cycle, plus literal
//               expectations at key points of each scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

    localparam int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_stall;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst), .halt(halt),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
        .d_stall(d_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory contents as a pure function of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h100) return 32'h00500093;
        return (a * 32'h9E3779B1) ^ 32'h13572468;
    endfunction

    assign mem_rdata = memf(mem_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: owner of the memory and the absolute cycles of its
    // grant and completion.
    int          m_own = 0;       // 0 none, 1 fetch, 2 data
    int          m_grant_cyc = 0;
    int          m_done_cyc = 0;
    logic        m_last_data = 1'b0;
    logic        m_we = 1'b0;
    logic [3:0]  m_be = '0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;

    always @(negedge clk) begin
        logic done, e_ifv, e_dv, fc, dc;
        logic [31:0] e_ifr, e_dr;
        if (!rst) begin
            m_own = 0; m_last_data = 1'b0; m_we = 1'b0; m_be = '0;
            m_addr = '0; m_wdata = '0;
            chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
            chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
            chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
            chk("rst_mem_addr", mem_addr, 32'd0);
            chk("rst_mem_wdata", mem_wdata, 32'd0);
            chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
            chk("rst_d_valid", {31'd0, d_valid}, 32'd0);
            chk("rst_if_rdata", if_rdata, 32'd0);
            chk("rst_d_rdata", d_rdata, 32'd0);
        end else begin
            done  = (m_own != 0) && (cyc == m_done_cyc);
            e_ifv = done && (m_own == 1);
            e_dv  = done && (m_own == 2);
            e_ifr = e_ifv ? memf(m_addr) : 32'd0;
            e_dr  = (e_dv && !m_we) ? memf(m_addr) : 32'd0;
            chk("if_valid", {31'd0, if_valid}, {31'd0, e_ifv});
            chk("if_rdata", if_rdata, e_ifr);
            chk("if_stall", {31'd0, if_stall}, {31'd0, if_req & ~e_ifv});
            chk("d_valid", {31'd0, d_valid}, {31'd0, e_dv});
            chk("d_rdata", d_rdata, e_dr);
            chk("d_stall", {31'd0, d_stall}, {31'd0, d_req & ~e_dv});
            chk("mem_en", {31'd0, mem_en},
                {31'd0, (m_own != 0) && (cyc == m_grant_cyc + 1)});
            chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
            chk("mem_be", {28'd0, mem_be}, {28'd0, m_be});
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            if (m_own == 0 || done) begin
                fc = if_req && !halt;
                dc = d_req;
                if (dc && (!fc || !m_last_data)) begin
                    m_own = 2; m_addr = d_addr; m_we = d_we; m_be = d_be;
                    m_wdata = d_wdata; m_last_data = 1'b1;
                    m_grant_cyc = cyc; m_done_cyc = cyc + 1 + MEM_LAT;
                end else if (fc) begin
                    m_own = 1; m_addr = if_addr; m_we = 1'b0; m_be = 4'hF;
                    m_wdata = 32'd0; m_last_data = 1'b0;
                    m_grant_cyc = cyc; m_done_cyc = cyc + 1 + MEM_LAT;
                end else begin
                    m_own = 0;
                end
            end
        end
        cyc++;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) next_cycle();
    endtask

    initial begin
        int nd, nf;
        rst = 1'b0; halt = 1'b0; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        idle(3);
        rst = 1'b1;
        idle(3);

        // Fetch only
        next_cycle(); if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk); chk("t1_stall_c0", {31'd0, if_stall}, 32'd1);
                        chk("t1_en_c0", {31'd0, mem_en}, 32'd0);
        @(negedge clk); chk("t1_en_c1", {31'd0, mem_en}, 32'd1);
                        chk("t1_addr_c1", mem_addr, 32'h100);
                        chk("t1_be_c1", {28'd0, mem_be}, 32'hF);
                        chk("t1_we_c1", {31'd0, mem_we}, 32'd0);
                        chk("t1_stall_c1", {31'd0, if_stall}, 32'd1);
        @(negedge clk); chk("t1_stall_c2", {31'd0, if_stall}, 32'd1);
        @(negedge clk); chk("t1_valid_c3", {31'd0, if_valid}, 32'd1);
                        chk("t1_rdata_c3", if_rdata, 32'h00500093);
        next_cycle(); if_req = 1'b0;
        idle(8);

        // Simultaneous requests, last grant was fetch
        next_cycle(); if_req = 1'b1; if_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h200;
        @(negedge clk);
        @(negedge clk); chk("t2_en_c1", {31'd0, mem_en}, 32'd1);
                        chk("t2_addr_c1", mem_addr, 32'h200);
        @(negedge clk);
        @(negedge clk); chk("t2_dvalid_c3", {31'd0, d_valid}, 32'd1);
        next_cycle(); d_req = 1'b0;
        @(negedge clk); chk("t2_en_c4", {31'd0, mem_en}, 32'd1);
                        chk("t2_addr_c4", mem_addr, 32'h300);
        @(negedge clk);
        @(negedge clk); chk("t2_ifvalid_c6", {31'd0, if_valid}, 32'd1);
        next_cycle(); if_req = 1'b0;
        idle(8);

        // Fairness under continuous contention
        next_cycle(); if_req = 1'b1; if_addr = 32'h700;
        d_req = 1'b1; d_addr = 32'h800;
        nd = 0; nf = 0;
        repeat (25) begin
            @(negedge clk);
            nd += int'(d_valid);
            nf += int'(if_valid);
        end
        chk("t3_d_count", nd, 32'd4);
        chk("t3_if_count", nf, 32'd4);
        next_cycle(); if_req = 1'b0; d_req = 1'b0;
        idle(8);

        // Store
        next_cycle(); d_req = 1'b1; d_we = 1'b1; d_be = 4'h3;
        d_addr = 32'h40; d_wdata = 32'hABCD1234;
        @(negedge clk);
        @(negedge clk); chk("t4_en_c1", {31'd0, mem_en}, 32'd1);
                        chk("t4_we_c1", {31'd0, mem_we}, 32'd1);
                        chk("t4_be_c1", {28'd0, mem_be}, 32'h3);
                        chk("t4_wdata_c1", mem_wdata, 32'hABCD1234);
        @(negedge clk); chk("t4_en_c2", {31'd0, mem_en}, 32'd0);
        @(negedge clk); chk("t4_dvalid_c3", {31'd0, d_valid}, 32'd1);
                        chk("t4_drdata_c3", d_rdata, 32'd0);
        next_cycle(); d_req = 1'b0; d_we = 1'b0;
        idle(8);

        // Halt blocks new fetches
        next_cycle(); halt = 1'b1; if_req = 1'b1; if_addr = 32'h900;
        repeat (10) begin
            @(negedge clk);
            chk("t5_halt_en", {31'd0, mem_en}, 32'd0);
            chk("t5_halt_stall", {31'd0, if_stall}, 32'd1);
        end
        // Halt raised during an in-flight fetch
        next_cycle(); halt = 1'b0; if_addr = 32'h500;
        next_cycle(); halt = 1'b1;
        @(negedge clk); chk("t5_en_c1", {31'd0, mem_en}, 32'd1);
                        chk("t5_addr_c1", mem_addr, 32'h500);
        @(negedge clk);
        @(negedge clk); chk("t5_ifvalid_c3", {31'd0, if_valid}, 32'd1);
        next_cycle(); if_req = 1'b0; halt = 1'b0;
        idle(8);

        // Reset in the middle of a data access
        next_cycle(); if_req = 1'b1; if_addr = 32'hA00;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
        @(negedge clk);
        @(negedge clk); chk("t6_en_c1", {31'd0, mem_en}, 32'd1);
        next_cycle(); rst = 1'b0;
        #1;
        chk("t6_async_addr", mem_addr, 32'd0);
        chk("t6_async_be", {28'd0, mem_be}, 32'd0);
        next_cycle();
        next_cycle(); rst = 1'b1;
        @(negedge clk); chk("t6_r0_dvalid", {31'd0, d_valid}, 32'd0);
                        chk("t6_r0_en", {31'd0, mem_en}, 32'd0);
        @(negedge clk); chk("t6_r1_en", {31'd0, mem_en}, 32'd1);
                        chk("t6_r1_addr", mem_addr, 32'h600);
        @(negedge clk); chk("t6_r2_dvalid", {31'd0, d_valid}, 32'd0);
        @(negedge clk); chk("t6_r3_dvalid", {31'd0, d_valid}, 32'd1);
        next_cycle(); d_req = 1'b0;
        @(negedge clk); chk("t6_r4_addr", mem_addr, 32'hA00);
        @(negedge clk);
        @(negedge clk); chk("t6_r6_ifvalid", {31'd0, if_valid}, 32'd1);
        next_cycle(); if_req = 1'b0;
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the fetch stage and the load/store path of the RV32 core.
- Sequences each access through a fixed-latency memory.
- Arbitrates between fetch and data requests with a fairness rule.
- Honours the decoder's halt (PC_enable=0 on ECALL/EBREAK/system opcodes) by blocking new fetches.
- Generates per-requester stall signals for the pipeline.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte enables are DATA_W/8 bits)
MEM_LAT, 2, cycles from mem_en high to mem_rdata valid; legal range 1..4

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
halt  input  1  from control (inverse of PC_enable); blocks new fetch grants
if_req  input  1  fetch request; held until if_valid
if_addr  input  ADDR_W  fetch address, stable while if_req
if_rdata  output  DATA_W  instruction word; valid only when if_valid
if_valid  output  1  one-cycle fetch completion pulse
if_stall  output  1  if_req & ~if_valid
d_req  input  1  data request; held until d_valid
d_we  input  1  1=store, 0=load
d_be  input  DATA_W/8  byte enables
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_rdata  output  DATA_W  load data; 0 for stores and when not valid
d_valid  output  1  one-cycle data completion pulse (loads and stores)
d_stall  output  1  d_req & ~d_valid
mem_en  output  1  one-cycle access strobe
mem_we  output  1  write enable, qualified by mem_en
mem_be  output  DATA_W/8  byte enables (all ones for fetch)
mem_addr  output  ADDR_W  registered address
mem_wdata  output  DATA_W  registered write data
mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, counter=0, last_grant=FETCH.
  - All outputs 0: mem_en, mem_we, mem_be, mem_addr, mem_wdata, if_valid, d_valid, if_rdata, d_rdata.
  - Any in-flight access is discarded with no valid pulse.
- States: IDLE, FETCH, DATA.
- Arbitration happens in IDLE and in any completion cycle (counter reaches 0 in FETCH/DATA):
  - Candidates: fetch = if_req & ~halt; data = d_req.
  - Only one candidate: grant it.
  - Both: grant DATA unless last_grant=DATA, then grant FETCH (no starvation).
  - Neither: go to IDLE.
- Grant edge:
  - Register the winner's addr, we (0 for fetch), be (all ones for fetch) and wdata (0 for fetch) into mem_*.
  - mem_en=1 for exactly the next cycle.
  - counter=MEM_LAT; last_grant=winner; move to the FETCH or DATA state.
- Counter decrements each cycle in FETCH/DATA.
- Completion cycle (counter=1 to 0 edge, i.e. MEM_LAT cycles after the mem_en cycle):
  - Combinationally assert if_valid or d_valid.
  - Drive if_rdata or d_rdata = mem_rdata (loads only).
- Latency: request seen in cycle N in IDLE → mem_en in N+1 → valid in N+1+MEM_LAT.
- Back-to-back throughput: one access per MEM_LAT+1 cycles (the next grant is taken in the completion cycle).
- mem_* hold their registered values between strobes; only mem_en is a pulse.
- halt:
  - Affects only new fetch grants.
  - An in-flight fetch still completes.
  - Data requests are unaffected.
  - if_stall stays high while if_req & halt.
- Request withdrawn before valid: protocol violation. The access still completes, the pulse is still emitted, and no abort is performed.
- Stores: d_valid pulses at the same latency; d_rdata=0.

Test Plan:
- MEM_LAT=2, fetch only:
  - Stimulus: if_req=1, if_addr=0x100 at cycle 0 (IDLE); mem_rdata=0x00500093 at cycle 3.
  - Response: mem_en=1, mem_addr=0x100, mem_be=0xF, mem_we=0 at cycle 1; if_valid=1, if_rdata=0x00500093 at cycle 3; if_stall=1 in cycles 0–2.
- Simultaneous requests with last_grant=FETCH:
  - Stimulus: if_req and d_req (load, 0x200) both asserted at cycle 0.
  - Response: DATA granted (mem_addr=0x200 at cycle 1, d_valid at cycle 3); FETCH granted in cycle 3 (mem_en at cycle 4, if_valid at cycle 6).
- Fairness:
  - Stimulus: d_req held continuously together with if_req.
  - Response: grants alternate DATA, FETCH, DATA, FETCH; each requester sees a valid every 6 cycles.
- Store:
  - Stimulus: d_we=1, d_be=0x3, d_addr=0x40, d_wdata=0xABCD1234.
  - Response: mem_we=1, mem_be=0x3, mem_wdata=0xABCD1234 with mem_en for one cycle; d_valid 2 cycles later; d_rdata=0.
- Halt:
  - Stimulus: halt=1 with if_req=1 for 10 cycles.
  - Response: no mem_en, if_stall=1 throughout.
  - Stimulus: halt asserted during an in-flight fetch.
  - Response: that fetch still completes.
- Reset mid-operation:
  - Stimulus: assert rst=0 one cycle after mem_en.
  - Response: all outputs 0 immediately (async); no valid pulse after release; next request behaves as from IDLE with DATA priority.
